// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding the ALU.
// Also raises the load-use stall request toward IF/ID.
module ex_operand_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [REGW-1:0] id_rs1_idx,
   input  logic [REGW-1:0] id_rs2_idx,
   input  logic [XLEN-1:0] id_rs1_val,
   input  logic [XLEN-1:0] id_rs2_val,
   input  logic [XLEN-1:0] id_imm,
   input  logic [REGW-1:0] id_rd,
   input  logic [3:0]      id_alu_ctrl,
   input  logic [1:0]      id_a_sel,
   input  logic            id_b_sel,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            stall,
   input  logic            flush,
   input  logic            exm_valid,
   input  logic            exm_reg_write,
   input  logic [REGW-1:0] exm_rd,
   input  logic [XLEN-1:0] exm_result,
   input  logic            wb_valid,
   input  logic            wb_reg_write,
   input  logic [REGW-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_result,
   output logic [XLEN-1:0] alu_inA,
   output logic [XLEN-1:0] alu_inB,
   output logic [3:0]      alu_ctrl,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic [REGW-1:0] ex_rd,
   output logic [XLEN-1:0] ex_store_data,
   output logic            load_use_stall
);

   logic [XLEN-1:0] pc_q;
   logic [REGW-1:0] rs1_idx_q;
   logic [REGW-1:0] rs2_idx_q;
   logic [XLEN-1:0] rs1_val_q;
   logic [XLEN-1:0] rs2_val_q;
   logic [XLEN-1:0] imm_q;
   logic [1:0]      a_sel_q;
   logic            b_sel_q;

   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;
   logic            exm_hit_rs1;
   logic            exm_hit_rs2;
   logic            wb_hit_rs1;
   logic            wb_hit_rs2;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         alu_ctrl     <= 4'b0000;
         ex_rd        <= '0;
         pc_q         <= '0;
         rs1_idx_q    <= '0;
         rs2_idx_q    <= '0;
         rs1_val_q    <= '0;
         rs2_val_q    <= '0;
         imm_q        <= '0;
         a_sel_q      <= 2'b00;
         b_sel_q      <= 1'b0;
      end else if (!stall) begin
         ex_valid     <= id_valid;
         ex_reg_write <= id_reg_write & id_valid;
         ex_mem_read  <= id_mem_read & id_valid;
         ex_mem_write <= id_mem_write & id_valid;
         alu_ctrl     <= id_alu_ctrl;
         ex_rd        <= id_rd;
         pc_q         <= id_pc;
         rs1_idx_q    <= id_rs1_idx;
         rs2_idx_q    <= id_rs2_idx;
         rs1_val_q    <= id_rs1_val;
         rs2_val_q    <= id_rs2_val;
         imm_q        <= id_imm;
         a_sel_q      <= id_a_sel;
         b_sel_q      <= id_b_sel;
      end
   end

   // x0 is hardwired zero upstream, so a producer targeting it must never be forwarded.
   always_comb begin
      exm_hit_rs1 = exm_valid && exm_reg_write && (exm_rd != '0) && (exm_rd == rs1_idx_q);
      exm_hit_rs2 = exm_valid && exm_reg_write && (exm_rd != '0) && (exm_rd == rs2_idx_q);
      wb_hit_rs1  = wb_valid && wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_idx_q);
      wb_hit_rs2  = wb_valid && wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_idx_q);

      fwd_rs1 = rs1_val_q;
      if (exm_hit_rs1)
         fwd_rs1 = exm_result;
      else if (wb_hit_rs1)
         fwd_rs1 = wb_result;

      fwd_rs2 = rs2_val_q;
      if (exm_hit_rs2)
         fwd_rs2 = exm_result;
      else if (wb_hit_rs2)
         fwd_rs2 = wb_result;
   end

   always_comb begin
      alu_inA = '0;
      case (a_sel_q)
         2'b00:   alu_inA = fwd_rs1;
         2'b01:   alu_inA = pc_q;
         default: alu_inA = '0;
      endcase
      alu_inB       = b_sel_q ? imm_q : fwd_rs2;
      ex_store_data = fwd_rs2;
   end

   // Upstream turns this into IF/ID stall plus a flush here; no bubble is inserted locally.
   assign load_use_stall = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                           ((ex_rd == id_rs1_idx) || (ex_rd == id_rs2_idx));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed and random checks of ex_operand_stage against a behavioural pipeline-slot model.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1_idx, id_rs2_idx;
   logic [31:0] id_rs1_val, id_rs2_val, id_imm;
   logic [4:0]  id_rd;
   logic [3:0]  id_alu_ctrl;
   logic [1:0]  id_a_sel;
   logic        id_b_sel, id_reg_write, id_mem_read, id_mem_write;
   logic        stall, flush;
   logic        exm_valid, exm_reg_write;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        wb_valid, wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic [31:0] alu_inA, alu_inB, ex_store_data;
   logic [3:0]  alu_ctrl;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
   logic [4:0]  ex_rd;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
      .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
      .id_imm(id_imm), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
      .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .stall(stall), .flush(flush),
      .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_ctrl(alu_ctrl),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
      .load_use_stall(load_use_stall)
   );

   // The instruction currently sitting in EX, as the model sees it.
   typedef struct {
      bit          valid;
      bit [31:0]   pc;
      bit [4:0]    src_idx [2];
      bit [31:0]   src_val [2];
      bit [31:0]   imm;
      bit [4:0]    rd;
      bit [3:0]    op;
      bit [1:0]    a_sel;
      bit          b_sel;
      bit          wr, ld, st;
   } slot_t;

   slot_t m;

   function automatic slot_t empty_slot();
      slot_t s;
      s.valid = 0; s.pc = 0; s.imm = 0; s.rd = 0; s.op = 0; s.a_sel = 0; s.b_sel = 0;
      s.wr = 0; s.ld = 0; s.st = 0;
      s.src_idx[0] = 0; s.src_idx[1] = 0; s.src_val[0] = 0; s.src_val[1] = 0;
      return s;
   endfunction

   task automatic model_clock();
      if (rst || flush) m = empty_slot();
      else if (!stall) begin
         m.valid = id_valid; m.pc = id_pc; m.imm = id_imm; m.rd = id_rd; m.op = id_alu_ctrl;
         m.a_sel = id_a_sel; m.b_sel = id_b_sel;
         m.wr = id_reg_write && id_valid; m.ld = id_mem_read && id_valid; m.st = id_mem_write && id_valid;
         m.src_idx[0] = id_rs1_idx; m.src_idx[1] = id_rs2_idx;
         m.src_val[0] = id_rs1_val; m.src_val[1] = id_rs2_val;
      end
   endtask

   // Youngest producer first; the first live writer of a nonzero matching register supplies the value.
   function automatic bit [31:0] operand(int k);
      bit        live [2];
      bit [4:0]  dst  [2];
      bit [31:0] data [2];
      live[0] = exm_valid && exm_reg_write; dst[0] = exm_rd; data[0] = exm_result;
      live[1] = wb_valid && wb_reg_write;   dst[1] = wb_rd;  data[1] = wb_result;
      if (m.src_idx[k] != 0)
         for (int p = 0; p < 2; p++)
            if (live[p] && dst[p] == m.src_idx[k]) return data[p];
      return m.src_val[k];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      bit [31:0] a_exp;
      bit        lus_exp;
      a_exp = (m.a_sel == 0) ? operand(0) : (m.a_sel == 1) ? m.pc : 32'h0;
      lus_exp = m.valid && m.ld && m.rd != 0 && id_valid &&
                (m.rd == id_rs1_idx || m.rd == id_rs2_idx);
      chk("alu_inA", alu_inA, a_exp);
      chk("alu_inB", alu_inB, m.b_sel ? m.imm : operand(1));
      chk("store_data", ex_store_data, operand(1));
      chk("alu_ctrl", 32'(alu_ctrl), 32'(m.op));
      chk("ex_valid", 32'(ex_valid), 32'(m.valid));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m.wr));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(m.ld));
      chk("ex_mem_write", 32'(ex_mem_write), 32'(m.st));
      chk("ex_rd", 32'(ex_rd), 32'(m.rd));
      chk("load_use_stall", 32'(load_use_stall), 32'(lus_exp));
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic no_fwd();
      exm_valid = 0; exm_reg_write = 0; exm_rd = 0; exm_result = 0;
      wb_valid = 0; wb_reg_write = 0; wb_rd = 0; wb_result = 0;
   endtask

   task automatic set_id(bit v, bit [4:0] r1, bit [31:0] v1, bit [4:0] r2, bit [31:0] v2,
                         bit [4:0] rd, bit [3:0] op, bit [1:0] asel, bit bsel);
      id_valid = v; id_rs1_idx = r1; id_rs1_val = v1; id_rs2_idx = r2; id_rs2_val = v2;
      id_rd = rd; id_alu_ctrl = op; id_a_sel = asel; id_b_sel = bsel;
   endtask

   logic [31:0] held_a, held_b;

   initial begin
      m = empty_slot();
      rst = 1; stall = 0; flush = 0;
      id_pc = 0; id_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      no_fwd();
      #2;
      tick(); rst = 0;

      // reset after a valid add was captured
      set_id(1, 1, 32'h11, 2, 32'h22, 3, 4'b0000, 0, 0); id_reg_write = 1;
      tick();
      chk("pre_reset_valid", 32'(ex_valid), 1);
      rst = 1;
      tick(); rst = 0;
      #1;
      chk("rst_valid", 32'(ex_valid), 0);
      chk("rst_ctrl", 32'(alu_ctrl), 0);
      chk("rst_inA", alu_inA, 0);
      chk("rst_inB", alu_inB, 0);
      chk("rst_lus", 32'(load_use_stall), 0);
      check_model();

      // plain capture
      set_id(1, 1, 5, 2, 7, 4, 4'b0001, 0, 0);
      tick(); #1;
      chk("cap_inA", alu_inA, 5);
      chk("cap_inB", alu_inB, 7);
      chk("cap_ctrl", 32'(alu_ctrl), 1);
      chk("cap_valid", 32'(ex_valid), 1);
      check_model();

      // forwarding priority on rs1 = x3
      set_id(1, 3, 32'h55, 2, 7, 4, 4'b0001, 0, 0);
      tick();
      exm_valid = 1; exm_reg_write = 1; exm_rd = 3; exm_result = 32'hDEAD0000;
      wb_valid = 1; wb_reg_write = 1; wb_rd = 3; wb_result = 32'h1;
      #1; chk("fwd_exm_wins", alu_inA, 32'hDEAD0000); check_model();
      exm_reg_write = 0;
      #1; chk("fwd_wb", alu_inA, 32'h1); check_model();

      // x0 never forwarded
      set_id(1, 0, 32'h1234, 2, 7, 4, 4'b0001, 0, 0);
      tick();
      exm_reg_write = 1; exm_rd = 0; wb_rd = 0;
      #1; chk("fwd_x0", alu_inA, 32'h1234); check_model();

      // PC / immediate selects, store data still forwarded rs2
      no_fwd();
      set_id(1, 1, 9, 6, 32'h77, 4, 4'b0010, 2'b01, 1); id_pc = 32'h100; id_imm = 32'hFFFFF800;
      tick();
      wb_valid = 1; wb_reg_write = 1; wb_rd = 6; wb_result = 32'hABCD;
      #1;
      chk("sel_inA_pc", alu_inA, 32'h100);
      chk("sel_inB_imm", alu_inB, 32'hFFFFF800);
      chk("sel_store", ex_store_data, 32'hABCD);
      check_model();
      no_fwd();
      held_a = alu_inA; held_b = alu_inB;

      // stall holds for 3 cycles while id_* changes
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         set_id(1, 5'(i + 7), $urandom, 5'(i + 9), $urandom, 5'(i + 2), 4'(i + 5), 0, 0);
         id_pc = $urandom; id_imm = $urandom;
         tick(); #1;
         chk("stall_inA", alu_inA, held_a);
         chk("stall_inB", alu_inB, held_b);
         chk("stall_ctrl", 32'(alu_ctrl), 2);
         check_model();
      end

      // flush beats stall
      flush = 1;
      tick(); #1;
      chk("flush_valid", 32'(ex_valid), 0);
      chk("flush_rw", 32'(ex_reg_write), 0);
      chk("flush_ctrl", 32'(alu_ctrl), 0);
      check_model();
      flush = 0; stall = 0;

      // load-use detection
      set_id(1, 1, 0, 2, 0, 5, 4'b0000, 0, 1); id_mem_read = 1; id_reg_write = 1;
      tick();
      id_mem_read = 0; id_reg_write = 0;
      set_id(1, 1, 0, 5, 0, 8, 4'b0000, 0, 0);
      #1; chk("lus_hit", 32'(load_use_stall), 1); check_model();
      id_valid = 0;
      #1; chk("lus_idle", 32'(load_use_stall), 0); check_model();
      set_id(1, 1, 0, 2, 0, 0, 4'b0000, 0, 1); id_mem_read = 1;
      tick();
      id_mem_read = 0;
      set_id(1, 0, 0, 0, 0, 8, 4'b0000, 0, 0);
      #1; chk("lus_rd0", 32'(load_use_stall), 0); check_model();

      // reset wins over a concurrent stall
      set_id(1, 1, 3, 2, 4, 6, 4'b0011, 0, 0); id_reg_write = 1;
      tick();
      stall = 1; rst = 1;
      tick(); #1;
      chk("rst_over_stall", 32'(ex_valid), 0);
      check_model();
      stall = 0; rst = 0;

      // random traffic, small index space so hazards are frequent
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 9) == 0);
         stall = ($urandom_range(0, 5) == 0);
         set_id(1'($urandom), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                5'($urandom_range(0, 3)), 4'($urandom_range(0, 10)), 2'($urandom), 1'($urandom));
         id_pc = $urandom; id_imm = $urandom;
         id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
         tick();
         exm_valid = 1'($urandom); exm_reg_write = 1'($urandom);
         exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
         wb_valid = 1'($urandom); wb_reg_write = 1'($urandom);
         wb_rd = 5'($urandom_range(0, 3)); wb_result = $urandom;
         id_valid = 1'($urandom);
         id_rs1_idx = 5'($urandom_range(0, 3)); id_rs2_idx = 5'($urandom_range(0, 3));
         #1;
         check_model();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
